// File: rtl/riscv_v_rf.sv
// Vector register file: NUM_VREGS x VLEN, byte-enabled write, two registered read ports, registered v0 mask.
// Optional macro RISCV_V_RF_BYPASS_EN forwards same-cycle writes to the read ports and the mask.
module riscv_v_rf #(
    parameter int VLEN      = 128,
    parameter int NUM_VREGS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        wr_addr,
    input  logic [4:0]        rd_addr_A,
    input  logic [4:0]        rd_addr_B,
    input  logic [VLEN-1:0]   data_in,
    input  logic [VLEN/8-1:0] wr_en,
    output logic [VLEN-1:0]   data_out_A,
    output logic [VLEN-1:0]   data_out_B,
    output logic [VLEN-1:0]   mask
);

    localparam int NB = VLEN / 8;

    logic [VLEN-1:0] regs [NUM_VREGS];
    logic [VLEN-1:0] rd_a;
    logic [VLEN-1:0] rd_b;
    logic [VLEN-1:0] v0_next;

    function automatic logic [VLEN-1:0] merge_bytes(
        input logic [VLEN-1:0] old_d,
        input logic [VLEN-1:0] new_d,
        input logic [NB-1:0]   en
    );
        logic [VLEN-1:0] res;
        res = old_d;
        for (int b = 0; b < NB; b++) begin
            if (en[b]) res[8*b +: 8] = new_d[8*b +: 8];
        end
        return res;
    endfunction

    // Read selection: addresses matching no register fall through to zero.
    always_comb begin
        rd_a    = '0;
        rd_b    = '0;
        v0_next = regs[0];
        for (int i = 0; i < NUM_VREGS; i++) begin
            logic [VLEN-1:0] cur;
            cur = regs[i];
`ifdef RISCV_V_RF_BYPASS_EN
            if ((|wr_en) && (wr_addr == 5'(i))) cur = merge_bytes(regs[i], data_in, wr_en);
`endif
            if (rd_addr_A == 5'(i)) rd_a = cur;
            if (rd_addr_B == 5'(i)) rd_b = cur;
            if (i == 0) v0_next = cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VREGS; i++) regs[i] <= '0;
            data_out_A <= '0;
            data_out_B <= '0;
            mask       <= '0;
        end else begin
            // Out-of-range wr_addr matches no index, so the write is dropped.
            for (int i = 0; i < NUM_VREGS; i++) begin
                if (wr_addr == 5'(i)) regs[i] <= merge_bytes(regs[i], data_in, wr_en);
            end
            data_out_A <= rd_a;
            data_out_B <= rd_b;
            mask       <= v0_next;
        end
    end

endmodule

// File: tb/tb_riscv_v_rf.sv
// Directed self-checking bench for riscv_v_rf; expectations follow RISCV_V_RF_BYPASS_EN if defined.
module tb_riscv_v_rf;

    localparam int VLEN  = 128;
    localparam int NREGS = 30;

    logic              clk = 1'b0;
    logic              rst;
    logic [4:0]        wr_addr;
    logic [4:0]        rd_addr_A;
    logic [4:0]        rd_addr_B;
    logic [VLEN-1:0]   data_in;
    logic [VLEN/8-1:0] wr_en;
    logic [VLEN-1:0]   data_out_A;
    logic [VLEN-1:0]   data_out_B;
    logic [VLEN-1:0]   mask;

    int vectors = 0;
    int errors  = 0;

    riscv_v_rf #(.VLEN(VLEN), .NUM_VREGS(NREGS)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_addr    (wr_addr),
        .rd_addr_A  (rd_addr_A),
        .rd_addr_B  (rd_addr_B),
        .data_in    (data_in),
        .wr_en      (wr_en),
        .data_out_A (data_out_A),
        .data_out_B (data_out_B),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [VLEN-1:0] d, input logic [15:0] e);
        wr_addr = a;
        data_in = d;
        wr_en   = e;
        step();
        wr_en   = '0;
        data_in = '0;
    endtask

    task automatic test_reset();
        if (data_out_A !== '0) begin errors++; $display("FAIL rst_out_a got %h want 0", data_out_A); end
        vectors++;
        if (data_out_B !== '0) begin errors++; $display("FAIL rst_out_b got %h want 0", data_out_B); end
        vectors++;
        if (mask !== '0) begin errors++; $display("FAIL rst_mask got %h want 0", mask); end
        vectors++;
        rst = 1'b0;
        do_write(5'd3, {VLEN{1'b1}}, 16'hFFFF);
        do_write(5'd0, 128'hDEAD, 16'hFFFF);
        rd_addr_A = 5'd3;
        step();
        if (data_out_A !== {VLEN{1'b1}}) begin errors++; $display("FAIL pre_rst_v3 got %h want all ones", data_out_A); end
        vectors++;
        if (mask !== 128'hDEAD) begin errors++; $display("FAIL pre_rst_mask got %h want dead", mask); end
        vectors++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        if (data_out_A !== '0) begin errors++; $display("FAIL rst_edge_a got %h want 0", data_out_A); end
        vectors++;
        if (mask !== '0) begin errors++; $display("FAIL rst_edge_mask got %h want 0", mask); end
        vectors++;
        step();
        if (data_out_A !== '0) begin errors++; $display("FAIL post_rst_v3 got %h want 0", data_out_A); end
        vectors++;
        if (mask !== '0) begin errors++; $display("FAIL post_rst_mask got %h want 0", mask); end
        vectors++;
    endtask

    task automatic test_byte_write();
        do_write(5'd5, '0, 16'hFFFF);
        do_write(5'd5, 128'h112233445566778899AABBCCDDEEFF00, 16'h00FF);
        rd_addr_A = 5'd5;
        step();
        if (data_out_A !== 128'h000000000000000099AABBCCDDEEFF00) begin
            errors++; $display("FAIL byte_low8 got %h want 000000000000000099aabbccddeeff00", data_out_A);
        end
        vectors++;
        do_write(5'd5, {16{8'hEE}}, 16'hF000);
        step();
        if (data_out_A !== 128'hEEEEEEEE0000000099AABBCCDDEEFF00) begin
            errors++; $display("FAIL byte_top4 got %h want eeeeeeee0000000099aabbccddeeff00", data_out_A);
        end
        vectors++;
        do_write(5'd5, {16{8'h77}}, 16'h0000);
        step();
        if (data_out_A !== 128'hEEEEEEEE0000000099AABBCCDDEEFF00) begin
            errors++; $display("FAIL byte_noop got %h want eeeeeeee0000000099aabbccddeeff00", data_out_A);
        end
        vectors++;
    endtask

    task automatic test_dual_read();
        do_write(5'd1, {16{8'hA5}}, 16'hFFFF);
        do_write(5'd2, {16{8'h5A}}, 16'hFFFF);
        rd_addr_A = 5'd1;
        rd_addr_B = 5'd2;
        step();
        if (data_out_A !== {16{8'hA5}}) begin errors++; $display("FAIL dual_a got %h want a5..a5", data_out_A); end
        vectors++;
        if (data_out_B !== {16{8'h5A}}) begin errors++; $display("FAIL dual_b got %h want 5a..5a", data_out_B); end
        vectors++;
        rd_addr_B = 5'd1;
        step();
        if (data_out_A !== {16{8'hA5}}) begin errors++; $display("FAIL same_a got %h want a5..a5", data_out_A); end
        vectors++;
        if (data_out_B !== {16{8'hA5}}) begin errors++; $display("FAIL same_b got %h want a5..a5", data_out_B); end
        vectors++;
        rd_addr_B = 5'd0;
    endtask

    task automatic test_hazard();
        logic [VLEN-1:0] exp_a;
        do_write(5'd7, '0, 16'hFFFF);
        rd_addr_A = 5'd7;
        do_write(5'd7, {16{8'h33}}, 16'hFFFF);
`ifdef RISCV_V_RF_BYPASS_EN
        exp_a = {16{8'h33}};
`else
        exp_a = '0;
`endif
        if (data_out_A !== exp_a) begin errors++; $display("FAIL hazard_same got %h want %h", data_out_A, exp_a); end
        vectors++;
        rd_addr_A = 5'd5;
        do_write(5'd5, {16{8'h44}}, 16'h0003);
`ifdef RISCV_V_RF_BYPASS_EN
        exp_a = 128'hEEEEEEEE0000000099AABBCCDDEE4444;
`else
        exp_a = 128'hEEEEEEEE0000000099AABBCCDDEEFF00;
`endif
        if (data_out_A !== exp_a) begin errors++; $display("FAIL hazard_merge got %h want %h", data_out_A, exp_a); end
        vectors++;
        rd_addr_A = 5'd7;
        step();
        if (data_out_A !== {16{8'h33}}) begin errors++; $display("FAIL hazard_after got %h want 33..33", data_out_A); end
        vectors++;
    endtask

    task automatic test_mask();
        logic [VLEN-1:0] exp_m;
        do_write(5'd0, 128'hF0, 16'hFFFF);
`ifdef RISCV_V_RF_BYPASS_EN
        exp_m = 128'hF0;
`else
        exp_m = '0;
`endif
        if (mask !== exp_m) begin errors++; $display("FAIL mask_edge_n got %h want %h", mask, exp_m); end
        vectors++;
        step();
        if (mask !== 128'hF0) begin errors++; $display("FAIL mask_edge_n1 got %h want f0", mask); end
        vectors++;
        do_write(5'd4, {VLEN{1'b1}}, 16'hFFFF);
        step();
        if (mask !== 128'hF0) begin errors++; $display("FAIL mask_v4 got %h want f0", mask); end
        vectors++;
        do_write(5'd0, {16{8'h5A}}, 16'h0002);
        step();
        if (mask !== 128'h5AF0) begin errors++; $display("FAIL mask_byte got %h want 5af0", mask); end
        vectors++;
    endtask

    task automatic test_out_of_range();
        do_write(5'd31, {16{8'h99}}, 16'hFFFF);
        do_write(5'd30, {16{8'h88}}, 16'hFFFF);
        rd_addr_A = 5'd31;
        rd_addr_B = 5'd30;
        step();
        if (data_out_A !== '0) begin errors++; $display("FAIL oor_rd31 got %h want 0", data_out_A); end
        vectors++;
        if (data_out_B !== '0) begin errors++; $display("FAIL oor_rd30 got %h want 0", data_out_B); end
        vectors++;
        rd_addr_A = 5'd29;
        rd_addr_B = 5'd1;
        step();
        if (data_out_A !== '0) begin errors++; $display("FAIL oor_v29 got %h want 0", data_out_A); end
        vectors++;
        if (data_out_B !== {16{8'hA5}}) begin errors++; $display("FAIL oor_v1 got %h want a5..a5", data_out_B); end
        vectors++;
        rd_addr_B = 5'd0;
    endtask

    task automatic test_reset_mid_write();
        do_write(5'd9, {16{8'h77}}, 16'hFFFF);
        rd_addr_A = 5'd9;
        rst       = 1'b1;
        wr_addr   = 5'd9;
        data_in   = {16{8'h12}};
        wr_en     = 16'hFFFF;
        step();
        rst     = 1'b0;
        wr_addr = 5'd10;
        data_in = {16{8'hCC}};
        wr_en   = 16'hFFFF;
        if (data_out_A !== '0) begin errors++; $display("FAIL midrst_edge got %h want 0", data_out_A); end
        vectors++;
        step();
        wr_en   = '0;
        data_in = '0;
        if (data_out_A !== '0) begin errors++; $display("FAIL midrst_v9 got %h want 0", data_out_A); end
        vectors++;
        rd_addr_A = 5'd10;
        step();
        if (data_out_A !== {16{8'hCC}}) begin errors++; $display("FAIL first_edge_wr got %h want cc..cc", data_out_A); end
        vectors++;
        if (mask !== '0) begin errors++; $display("FAIL midrst_mask got %h want 0", mask); end
        vectors++;
    endtask

    initial begin
        rst       = 1'b1;
        wr_addr   = '0;
        rd_addr_A = '0;
        rd_addr_B = '0;
        data_in   = '0;
        wr_en     = '0;
        step();
        step();
        test_reset();
        test_byte_write();
        test_dual_read();
        test_hazard();
        test_mask();
        test_out_of_range();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
